panel_scan_master: RTL and testbench
====================================

// Module: panel_scan_master
// PURPOSE
//  Avalon-MM master driving the panel_6 register file from a physical front panel.
//  Every scan tick it samples and debounces the panel switches. It writes only changed
//  key/switch bits to the set/clear register pairs, and changed datasw/mas words. It then
//  reads back the lamp registers 0o12..0o25 into a local lamp buffer for the lamp driver.
// PARAMETERS
//  SCAN_DIV  50000  clocks between scan ticks (1 ms at 50 MHz); must be >= 64
// PORTS
//  clk            in   1   clock
//  reset          in   1   asynchronous, active-low reset
//  m_address      out  6   Avalon master word address
//  m_write        out  1   write request
//  m_read         out  1   read request
//  m_writedata    out  32  write data
//  m_readdata     in   32  read data, valid in the cycle m_read && !m_waitrequest
//  m_waitrequest  in   1   slave stall
//  sw_keys        in   9   bits 8:0 -> reg 0o00/0o01 bits 8:0 (start..addr_stop)
//  sw_keys2       in   10  bits 9:0 -> reg 0o02/0o03 bits 9:0 (dep..mem_disable)
//  sw_maint       in   5   bits 4:0 -> reg 0o04/0o05 bits 5:1
//  sw_data        in   36  data switches [0:35]; bit 0 is the MSB
//  sw_mas         in   18  address switches [18:35]
//  lamp_addr      in   4   lamp buffer index 0..11 (register 0o12+index)
//  lamp_data      out  18  lamp buffer word, combinational from lamp_addr; 0 for index > 11
//  scan_busy      out  1   high from tick accept until the last read completes
//  scan_done      out  1   one-cycle pulse after the last lamp read
// BEHAVIOUR
//  Reset values: all outputs 0, FSM IDLE, divider 0, shadows 0, debounce regs 0, lamp buffer 0.
//  Reset mid-transaction aborts the bus cycle immediately. Shadows are 0 = panel reset
//  values, so the first scan after reset writes every switch that is already on.
//  Inputs: 2-flop synchronizer, sampled at each tick into `prev`. A bit's debounced value
//   `stab` takes the new sample only when it equals `prev`, i.e. 2 consecutive ticks.
//  Divider counts 0..SCAN_DIV-1 and wraps. A tick arriving while busy is dropped;
//   there is no queue.
//  FSM: IDLE -> LATCH -> WR (steps 0..8) -> RD (index 0..11) -> DONE -> IDLE.
//   LATCH: compute set = stab & ~shadow and clr = ~stab & shadow per group.
//   WR steps, in order:
//     0o00 set0, 0o01 clr0, 0o02 set1, 0o03 clr1, 0o04 set2<<1, 0o05 clr2<<1,
//     0o06 {14'b0, data[0:17]} and 0o07 {14'b0, data[18:35]}, each only if that half changed,
//     0o10 {14'b0, mas} only if changed.
//   A step whose mask or data is unchanged is skipped with no bus cycle; skipping costs 1 clk.
//  Bus rules: address, write/read and writedata are held stable while m_waitrequest=1.
//   A transfer completes in the cycle the request is high and m_waitrequest=0.
//   Requests drop in the following cycle.
//   Never assert m_read and m_write together. At most one transfer is outstanding.
//  Shadows update only at write completion. set updates shadow |= mask; clr updates
//   shadow &= ~mask.
//  A switch flipping between LATCH and its write step is not lost: it is seen next scan.
//  RD: read 0o12+i and store m_readdata[17:0] into lamp[i] on completion.
//   The lamp buffer is updated word by word; a word never tears.
//  DONE: pulse scan_done, clear scan_busy, return to IDLE.
//  Latency with m_waitrequest=0: a scan with no changes takes 2+9+12*2+1 clocks.
// STRUCTURE
//  Shared package: panel register address constants (0o00..0o43) and lamp count (12).
//   panel_6 and this block both use it.
//  Sub-module avl_master_port: single-transfer request/hold/complete handshake, with a
//   start/ack interface toward the FSM. The FSM, shadows, debounce and lamp buffer live in
//   the top level.
// TESTING
//  Bench pairs the DUT with panel_6 plus a random-waitrequest stall injector. SCAN_DIV = 64.
//  1 Reset with sw_keys[0]=1 held for 2 ticks -> a single write 0o00 data 0x001;
//    panel key_start=1.
//  2 Release sw_keys[0] -> write 0o01 data 0x001; key_start=0; no other writes that scan.
//  3 sw_data=36'o123456_654321, 0o10 never written before -> write 0o06=0o123456,
//    0o07=0o654321. Re-scan with no change -> zero writes.
//  4 sw_maint=5'b00001 -> write 0o04 data 0x002 -> panel sw_rim_maint=1.
//  5 One-tick glitch on sw_keys2[8] -> no write. A 2-tick hold -> write 0o02 data 0x100.
//  6 Drive ir=18'o777000, pc=18'o001234 with waitrequest stalls of 0..5 clks ->
//    lamp[0]=0o777000, lamp[3]=0o001234. Requests held stable during stalls.
//    scan_done pulses once.
//    Assert reset mid-stall -> m_read=0 at once. The next scan rewrites all active switches.

Source files
------------

// File: rtl/panel_scan_master_pkg.sv
// rtl/panel_scan_master_pkg.sv - panel_6 register map, lamp count and scan FSM state type.
package panel_scan_master_pkg;

  localparam logic [5:0] REG_KEY_SET    = 6'o00;
  localparam logic [5:0] REG_KEY_CLR    = 6'o01;
  localparam logic [5:0] REG_KEY2_SET   = 6'o02;
  localparam logic [5:0] REG_KEY2_CLR   = 6'o03;
  localparam logic [5:0] REG_MAINT_SET  = 6'o04;
  localparam logic [5:0] REG_MAINT_CLR  = 6'o05;
  localparam logic [5:0] REG_DATA_HI    = 6'o06;
  localparam logic [5:0] REG_DATA_LO    = 6'o07;
  localparam logic [5:0] REG_MAS        = 6'o10;
  localparam logic [5:0] REG_LAMP_FIRST = 6'o12;
  localparam logic [5:0] REG_LAMP_LAST  = 6'o25;
  localparam logic [5:0] REG_LAST       = 6'o43;

  localparam int LAMP_COUNT = 12;
  localparam int WR_STEPS   = 9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_WR,
    ST_WR_WAIT,
    ST_RD,
    ST_RD_WAIT,
    ST_DONE
  } scan_state_t;

  function automatic logic [5:0] lamp_reg(input logic [3:0] idx);
    return REG_LAMP_FIRST + {2'b00, idx};
  endfunction

endpackage

// File: rtl/avl_master_port.sv
// rtl/avl_master_port.sv - single-transfer Avalon-MM master handshake with start/ack toward the FSM.
module avl_master_port (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        start_write,
  input  logic [5:0]  start_addr,
  input  logic [31:0] start_data,
  output logic        ack,
  output logic [5:0]  m_address,
  output logic        m_write,
  output logic        m_read,
  output logic [31:0] m_writedata,
  input  logic        m_waitrequest
);

  logic req;

  assign req = m_write | m_read;
  assign ack = req & ~m_waitrequest;

  // Request registers are held untouched while stalled; they clear the cycle after completion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_address   <= '0;
      m_write     <= 1'b0;
      m_read      <= 1'b0;
      m_writedata <= '0;
    end else if (start && !req) begin
      m_address   <= start_addr;
      m_write     <= start_write;
      m_read      <= ~start_write;
      m_writedata <= start_data;
    end else if (ack) begin
      m_address   <= '0;
      m_write     <= 1'b0;
      m_read      <= 1'b0;
      m_writedata <= '0;
    end
  end

endmodule

// File: rtl/panel_scan_master.sv
// rtl/panel_scan_master.sv - scans and debounces front-panel switches into panel_6, reads lamps back.
module panel_scan_master
  import panel_scan_master_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [5:0]  m_address,
  output logic        m_write,
  output logic        m_read,
  output logic [31:0] m_writedata,
  input  logic [31:0] m_readdata,
  input  logic        m_waitrequest,
  input  logic [8:0]  sw_keys,
  input  logic [9:0]  sw_keys2,
  input  logic [4:0]  sw_maint,
  input  logic [35:0] sw_data,
  input  logic [17:0] sw_mas,
  input  logic [3:0]  lamp_addr,
  output logic [17:0] lamp_data,
  output logic        scan_busy,
  output logic        scan_done
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int IN_W  = 78;

  scan_state_t state, state_n;

  logic [DIV_W-1:0] div;
  logic             tick;
  logic [IN_W-1:0]  raw, sync1, sync2, prev, stab, agree;

  logic [8:0]  stab_keys, set0, clr0, key_sh;
  logic [9:0]  stab_keys2, set1, clr1, key2_sh;
  logic [4:0]  stab_maint, set2, clr2, maint_sh;
  logic [35:0] stab_data, lat_data, data_sh;
  logic [17:0] stab_mas, lat_mas, mas_sh;
  logic [17:0] lamp [LAMP_COUNT];

  logic [3:0]  step, idx;
  logic [31:0] step_data;
  logic        step_need, last_step, last_lamp;
  logic        start, start_write, ack;
  logic [5:0]  start_addr;
  logic [31:0] start_data;
  logic        unused_rdata_hi;

  assign raw   = {sw_keys, sw_keys2, sw_maint, sw_data, sw_mas};
  assign tick  = (div == DIV_W'(SCAN_DIV - 1));
  assign agree = ~(sync2 ^ prev);

  assign stab_keys  = stab[77:69];
  assign stab_keys2 = stab[68:59];
  assign stab_maint = stab[58:54];
  assign stab_data  = stab[53:18];
  assign stab_mas   = stab[17:0];

  assign last_step       = (step == 4'(WR_STEPS - 1));
  assign last_lamp       = (idx == 4'(LAMP_COUNT - 1));
  assign scan_busy       = (state != ST_IDLE) && (state != ST_DONE);
  assign scan_done       = (state == ST_DONE);
  assign lamp_data       = (lamp_addr < 4'(LAMP_COUNT)) ? lamp[lamp_addr] : '0;
  assign unused_rdata_hi = ^m_readdata[31:18];

  // Divider and debounce run regardless of FSM state, so dropped ticks still age the samples.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div   <= '0;
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
      stab  <= '0;
    end else begin
      div   <= tick ? '0 : div + 1'b1;
      sync1 <= raw;
      sync2 <= sync1;
      if (tick) begin
        prev <= sync2;
        stab <= (agree & sync2) | (~agree & stab);
      end
    end
  end

  // Write step index doubles as the panel register address 0o00..0o10.
  always_comb begin
    step_data = '0;
    step_need = 1'b0;
    case (step)
      4'd0: begin step_data = {23'b0, set0};        step_need = |set0; end
      4'd1: begin step_data = {23'b0, clr0};        step_need = |clr0; end
      4'd2: begin step_data = {22'b0, set1};        step_need = |set1; end
      4'd3: begin step_data = {22'b0, clr1};        step_need = |clr1; end
      4'd4: begin step_data = {26'b0, set2, 1'b0};  step_need = |set2; end
      4'd5: begin step_data = {26'b0, clr2, 1'b0};  step_need = |clr2; end
      4'd6: begin
        step_data = {14'b0, lat_data[35:18]};
        step_need = (lat_data[35:18] != data_sh[35:18]);
      end
      4'd7: begin
        step_data = {14'b0, lat_data[17:0]};
        step_need = (lat_data[17:0] != data_sh[17:0]);
      end
      4'd8: begin
        step_data = {14'b0, lat_mas};
        step_need = (lat_mas != mas_sh);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_n     = state;
    start       = 1'b0;
    start_write = 1'b0;
    start_addr  = '0;
    start_data  = '0;
    unique case (state)
      ST_IDLE:  if (tick) state_n = ST_LATCH;
      ST_LATCH: state_n = ST_WR;
      ST_WR: begin
        if (step_need) begin
          start       = 1'b1;
          start_write = 1'b1;
          start_addr  = {2'b00, step};
          start_data  = step_data;
          state_n     = ST_WR_WAIT;
        end else if (last_step) begin
          state_n = ST_RD;
        end
      end
      ST_WR_WAIT: if (ack) state_n = last_step ? ST_RD : ST_WR;
      ST_RD: begin
        start      = 1'b1;
        start_addr = lamp_reg(idx);
        state_n    = ST_RD_WAIT;
      end
      ST_RD_WAIT: if (ack) state_n = last_lamp ? ST_DONE : ST_RD;
      ST_DONE:    state_n = ST_IDLE;
      default:    state_n = ST_IDLE;
    endcase
  end

  // Shadows follow completed writes only, so a change after LATCH shows up next scan.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      step     <= '0;
      idx      <= '0;
      set0     <= '0;
      clr0     <= '0;
      set1     <= '0;
      clr1     <= '0;
      set2     <= '0;
      clr2     <= '0;
      lat_data <= '0;
      lat_mas  <= '0;
      key_sh   <= '0;
      key2_sh  <= '0;
      maint_sh <= '0;
      data_sh  <= '0;
      mas_sh   <= '0;
      for (int i = 0; i < LAMP_COUNT; i++) lamp[i] <= '0;
    end else begin
      state <= state_n;
      case (state)
        ST_LATCH: begin
          set0     <= stab_keys & ~key_sh;
          clr0     <= ~stab_keys & key_sh;
          set1     <= stab_keys2 & ~key2_sh;
          clr1     <= ~stab_keys2 & key2_sh;
          set2     <= stab_maint & ~maint_sh;
          clr2     <= ~stab_maint & maint_sh;
          lat_data <= stab_data;
          lat_mas  <= stab_mas;
          step     <= '0;
          idx      <= '0;
        end
        ST_WR: if (!step_need) step <= step + 4'd1;
        ST_WR_WAIT: begin
          if (ack) begin
            step <= step + 4'd1;
            case (step)
              4'd0: key_sh          <= key_sh | set0;
              4'd1: key_sh          <= key_sh & ~clr0;
              4'd2: key2_sh         <= key2_sh | set1;
              4'd3: key2_sh         <= key2_sh & ~clr1;
              4'd4: maint_sh        <= maint_sh | set2;
              4'd5: maint_sh        <= maint_sh & ~clr2;
              4'd6: data_sh[35:18]  <= lat_data[35:18];
              4'd7: data_sh[17:0]   <= lat_data[17:0];
              4'd8: mas_sh          <= lat_mas;
              default: ;
            endcase
          end
        end
        ST_RD_WAIT: begin
          if (ack) begin
            lamp[idx] <= m_readdata[17:0];
            idx       <= idx + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  avl_master_port u_port (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .start_write   (start_write),
    .start_addr    (start_addr),
    .start_data    (start_data),
    .ack           (ack),
    .m_address     (m_address),
    .m_write       (m_write),
    .m_read        (m_read),
    .m_writedata   (m_writedata),
    .m_waitrequest (m_waitrequest)
  );

endmodule

// File: tb/tb_panel_scan_master.sv
// tb/tb_panel_scan_master.sv - randomized bench with a panel register model and stall-injecting slave.
module tb_panel_scan_master;

  localparam int SCAN_DIV = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [5:0]  m_address;
  logic        m_write, m_read;
  logic [31:0] m_writedata;
  logic [31:0] m_readdata = '0;
  logic        m_waitrequest = 1'b0;
  logic [8:0]  sw_keys = '0;
  logic [9:0]  sw_keys2 = '0;
  logic [4:0]  sw_maint = '0;
  logic [35:0] sw_data = '0;
  logic [17:0] sw_mas = '0;
  logic [3:0]  lamp_addr = '0;
  logic [17:0] lamp_data;
  logic        scan_busy, scan_done;

  always #5 clk = ~clk;

  panel_scan_master #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk(clk), .reset(reset),
    .m_address(m_address), .m_write(m_write), .m_read(m_read),
    .m_writedata(m_writedata), .m_readdata(m_readdata), .m_waitrequest(m_waitrequest),
    .sw_keys(sw_keys), .sw_keys2(sw_keys2), .sw_maint(sw_maint),
    .sw_data(sw_data), .sw_mas(sw_mas),
    .lamp_addr(lamp_addr), .lamp_data(lamp_data),
    .scan_busy(scan_busy), .scan_done(scan_done)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Panel register model: what panel_6 holds after the writes seen so far.
  logic [8:0]  pk_keys;
  logic [9:0]  pk_keys2;
  logic [4:0]  pk_maint;
  logic [35:0] pk_data;
  logic [17:0] pk_mas;
  logic [17:0] lamp_model [12];
  logic [5:0]  log_addr [$];
  logic [31:0] log_data [$];
  int          log_base = 0;
  int          max_stall = 0;

  logic        active = 1'b0, prev_done = 1'b0, cap_wr = 1'b0, prev_scan_done = 1'b0;
  logic [5:0]  cap_addr = '0;
  logic [31:0] cap_data = '0;
  int          stall = 0, busy_cnt = 0, last_busy = 0;

  task automatic apply_write(input logic [5:0] a, input logic [31:0] d);
    logic [31:0] mask;
    mask = '0;
    check("wr_addr_range", 64'(a <= 6'o10), 64'd1);
    case (a)
      6'o00: begin mask = 32'h1ff; check("wr_set0_new", 64'(d[8:0] & pk_keys), 64'd0); pk_keys |= d[8:0]; end
      6'o01: begin mask = 32'h1ff; check("wr_clr0_new", 64'(d[8:0] & ~pk_keys), 64'd0); pk_keys &= ~d[8:0]; end
      6'o02: begin mask = 32'h3ff; check("wr_set1_new", 64'(d[9:0] & pk_keys2), 64'd0); pk_keys2 |= d[9:0]; end
      6'o03: begin mask = 32'h3ff; check("wr_clr1_new", 64'(d[9:0] & ~pk_keys2), 64'd0); pk_keys2 &= ~d[9:0]; end
      6'o04: begin mask = 32'h03e; check("wr_set2_new", 64'(d[5:1] & pk_maint), 64'd0); pk_maint |= d[5:1]; end
      6'o05: begin mask = 32'h03e; check("wr_clr2_new", 64'(d[5:1] & ~pk_maint), 64'd0); pk_maint &= ~d[5:1]; end
      6'o06: begin mask = 32'h3ffff; check("wr_dhi_new", 64'(d[17:0] != pk_data[35:18]), 64'd1); pk_data[35:18] = d[17:0]; end
      6'o07: begin mask = 32'h3ffff; check("wr_dlo_new", 64'(d[17:0] != pk_data[17:0]), 64'd1); pk_data[17:0] = d[17:0]; end
      6'o10: begin mask = 32'h3ffff; check("wr_mas_new", 64'(d[17:0] != pk_mas), 64'd1); pk_mas = d[17:0]; end
      default: ;
    endcase
    check("wr_stray_bits", 64'(d & ~mask), 64'd0);
    log_addr.push_back(a);
    log_data.push_back(d);
  endtask

  // Avalon slave with random stalls, sampled on the falling edge.
  always @(negedge clk) begin
    if (!reset) begin
      active = 1'b0; prev_done = 1'b0; stall = 0; m_waitrequest = 1'b0; m_readdata = '0;
      pk_keys = '0; pk_keys2 = '0; pk_maint = '0; pk_data = '0; pk_mas = '0;
      busy_cnt = 0; prev_scan_done = 1'b0;
    end else begin
      check("rw_exclusive", 64'(m_read & m_write), 64'd0);
      if (prev_done) check("req_drop", 64'(m_read | m_write), 64'd0);
      prev_done = 1'b0;
      if (m_read | m_write) begin
        if (!active) begin
          active = 1'b1; cap_addr = m_address; cap_wr = m_write; cap_data = m_writedata;
          stall = int'($urandom_range(max_stall, 0));
        end else begin
          check("hold_addr", 64'(m_address), 64'(cap_addr));
          check("hold_write", 64'(m_write), 64'(cap_wr));
          check("hold_read", 64'(m_read), 64'(!cap_wr));
          check("hold_data", 64'(m_writedata), 64'(cap_data));
        end
        if (stall > 0) begin
          m_waitrequest = 1'b1;
          stall--;
        end else begin
          m_waitrequest = 1'b0; active = 1'b0; prev_done = 1'b1;
          if (m_write) apply_write(m_address, m_writedata);
          else if (m_address >= 6'o12 && m_address <= 6'o25)
            m_readdata = {14'($urandom), lamp_model[m_address - 6'o12]};
          else m_readdata = $urandom;
        end
      end else begin
        m_waitrequest = 1'($urandom_range(1, 0));
      end
      if (scan_busy) busy_cnt++;
      if (scan_done) begin
        check("done_single_cycle", 64'(prev_scan_done), 64'd0);
        last_busy = busy_cnt;
        busy_cnt = 0;
      end
      prev_scan_done = scan_done;
    end
  end

  task automatic wait_scans(input int n);
    int seen = 0;
    int cyc = 0;
    while (seen < n && cyc < n * 3000) begin
      @(negedge clk); #1;
      cyc++;
      if (scan_done) seen++;
    end
    if (seen < n) check("scan_timeout", 64'(seen), 64'(n));
  endtask

  task automatic expect_count(input string tag, input int n);
    check(tag, 64'(log_addr.size() - log_base), 64'(n));
  endtask

  task automatic expect_wr(input string tag, input int k, input logic [5:0] a, input logic [31:0] d);
    if (log_addr.size() > log_base + k) begin
      check({tag, "_addr"}, 64'(log_addr[log_base + k]), 64'(a));
      check({tag, "_data"}, 64'(log_data[log_base + k]), 64'(d));
    end
  endtask

  task automatic check_panel(input string tag);
    check({tag, "_keys"}, 64'(pk_keys), 64'(sw_keys));
    check({tag, "_keys2"}, 64'(pk_keys2), 64'(sw_keys2));
    check({tag, "_maint"}, 64'(pk_maint), 64'(sw_maint));
    check({tag, "_data"}, 64'(pk_data), 64'(sw_data));
    check({tag, "_mas"}, 64'(pk_mas), 64'(sw_mas));
  endtask

  task automatic check_lamps();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      lamp_addr = 4'(i);
      #1;
      check($sformatf("lamp%0d", i), 64'(lamp_data), (i < 12) ? 64'(lamp_model[i]) : 64'd0);
    end
  endtask

  initial begin
    int hit;
    int cyc;
    for (int i = 0; i < 12; i++) lamp_model[i] = 18'($urandom);
    sw_keys = 9'h001;
    repeat (3) @(negedge clk);
    #1;
    check("rst_m_write", 64'(m_write), 64'd0);
    check("rst_m_read", 64'(m_read), 64'd0);
    check("rst_m_address", 64'(m_address), 64'd0);
    check("rst_m_writedata", 64'(m_writedata), 64'd0);
    check("rst_scan_busy", 64'(scan_busy), 64'd0);
    check("rst_scan_done", 64'(scan_done), 64'd0);
    check("rst_lamp_data", 64'(lamp_data), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    log_base = log_addr.size();
    wait_scans(5);
    expect_count("t1_count", 1);
    expect_wr("t1_wr", 0, 6'o00, 32'h001);
    check_panel("t1");

    sw_keys = '0;
    log_base = log_addr.size();
    wait_scans(5);
    expect_count("t2_count", 1);
    expect_wr("t2_wr", 0, 6'o01, 32'h001);
    check_panel("t2");

    sw_data = 36'o123456_654321;
    log_base = log_addr.size();
    wait_scans(5);
    expect_count("t3_count", 2);
    expect_wr("t3_hi", 0, 6'o06, 32'o123456);
    expect_wr("t3_lo", 1, 6'o07, 32'o654321);
    log_base = log_addr.size();
    wait_scans(3);
    expect_count("t3_rescan", 0);

    sw_maint = 5'b00001;
    log_base = log_addr.size();
    wait_scans(5);
    expect_count("t4_count", 1);
    expect_wr("t4_wr", 0, 6'o04, 32'h002);
    check_panel("t4");

    sw_keys2[8] = 1'b1;
    repeat (40) @(negedge clk);
    sw_keys2[8] = 1'b0;
    log_base = log_addr.size();
    wait_scans(5);
    expect_count("t5_glitch", 0);
    sw_keys2[8] = 1'b1;
    log_base = log_addr.size();
    wait_scans(5);
    expect_count("t5_count", 1);
    expect_wr("t5_wr", 0, 6'o02, 32'h100);

    wait_scans(2);
    check("idle_scan_busy_len", 64'(last_busy), 64'd34);
    check_lamps();

    lamp_model[0] = 18'o777000;
    lamp_model[3] = 18'o001234;
    max_stall = 5;
    wait_scans(3);
    check_lamps();

    hit = 0;
    cyc = 0;
    while (hit == 0 && cyc < 5000) begin
      @(negedge clk); #1;
      cyc++;
      if (m_read && m_waitrequest) hit = 1;
    end
    check("stall_seen", 64'(hit), 64'd1);
    reset = 1'b0;
    #1;
    check("reset_abort_read", 64'(m_read), 64'd0);
    check("reset_abort_busy", 64'(scan_busy), 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    log_base = log_addr.size();
    wait_scans(5);
    expect_count("t6_rewrite_count", 4);
    expect_wr("t6_keys2", 0, 6'o02, 32'h100);
    expect_wr("t6_maint", 1, 6'o04, 32'h002);
    expect_wr("t6_dhi", 2, 6'o06, 32'o123456);
    expect_wr("t6_dlo", 3, 6'o07, 32'o654321);
    check_panel("t6");
    check_lamps();

    for (int it = 0; it < 6; it++) begin
      int b;
      max_stall = int'($urandom_range(3, 0));
      sw_keys  = 9'($urandom);
      sw_keys2 = 10'($urandom);
      sw_maint = 5'($urandom);
      sw_data  = {4'($urandom), $urandom};
      sw_mas   = 18'($urandom);
      for (int i = 0; i < 12; i++) lamp_model[i] = 18'($urandom);
      repeat (200) @(negedge clk);
      b = int'($urandom_range(9, 0));
      sw_keys2[b] = ~sw_keys2[b];
      repeat (30) @(negedge clk);
      sw_keys2[b] = ~sw_keys2[b];
      wait_scans(5);
      check_panel($sformatf("rnd%0d", it));
      check_lamps();
      log_base = log_addr.size();
      wait_scans(2);
      expect_count($sformatf("rnd%0d_quiet", it), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
